// File: rtl/systolic_array_nxn.sv
// rtl/systolic_array_nxn.sv - output-stationary NxN systolic multiplier with accumulate and saturation
module systolic_array_nxn #(
  parameter int N          = 2,
  parameter int DATA_WIDTH = 4,
  parameter int ACC_WIDTH  = 9
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_accum,
  input  logic [N*N*DATA_WIDTH-1:0]       a_flat,
  input  logic [N*N*DATA_WIDTH-1:0]       b_flat,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [N*N*ACC_WIDTH-1:0]        c_flat,
  output logic                            out_sat
);

  localparam int SW = $clog2(3*N);
  localparam int PW = 2*DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, FEED, LOAD, HOLD} state_t;

  state_t                      state, state_next;
  logic [SW-1:0]               step;
  logic                        accept;
  logic [N*N*DATA_WIDTH-1:0]   a_cap, b_cap;
  logic [DATA_WIDTH-1:0]       a_in [N][N];
  logic [DATA_WIDTH-1:0]       b_in [N][N];
  logic [DATA_WIDTH-1:0]       a_r  [N][N];
  logic [DATA_WIDTH-1:0]       b_r  [N][N];
  logic [PW-1:0]               prod [N][N];
  logic [ACC_WIDTH:0]          sum  [N][N];
  logic [ACC_WIDTH-1:0]        acc  [N][N];
  logic [N*N-1:0]              sat;

  assign in_ready  = (state == IDLE) || (state == HOLD && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = FEED;
      FEED: if (step == SW'(3*N-3)) state_next = LOAD;
      LOAD: state_next = HOLD;
      HOLD: begin
        if (accept)         state_next = FEED;
        else if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Edge PEs pick their operand straight out of the captured matrix; this realises the input skew.
  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_afeed
        logic [SW-1:0] ka;
        assign ka = step - SW'(i);
        assign a_in[i][j] = (step >= SW'(i) && ka < SW'(N)) ?
                            a_cap[(i*N + int'(ka))*DATA_WIDTH +: DATA_WIDTH] : '0;
      end else begin : g_ashift
        assign a_in[i][j] = a_r[i][j-1];
      end
      if (i == 0) begin : g_bfeed
        logic [SW-1:0] kb;
        assign kb = step - SW'(j);
        assign b_in[i][j] = (step >= SW'(j) && kb < SW'(N)) ?
                            b_cap[(int'(kb)*N + j)*DATA_WIDTH +: DATA_WIDTH] : '0;
      end else begin : g_bshift
        assign b_in[i][j] = b_r[i-1][j];
      end
      assign prod[i][j] = PW'(a_in[i][j]) * PW'(b_in[i][j]);
      assign sum[i][j]  = (ACC_WIDTH+1)'(acc[i][j]) + (ACC_WIDTH+1)'(prod[i][j]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      a_cap   <= '0;
      b_cap   <= '0;
      step    <= '0;
      sat     <= '0;
      c_flat  <= '0;
      out_sat <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          a_r[i][j] <= '0;
          b_r[i][j] <= '0;
          acc[i][j] <= '0;
        end
      end
    end else begin
      if (accept) begin
        a_cap <= a_flat;
        b_cap <= b_flat;
        step  <= '0;
        if (!in_accum) sat <= '0;
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            a_r[i][j] <= '0;
            b_r[i][j] <= '0;
            if (!in_accum) acc[i][j] <= '0;
          end
        end
      end else if (state == FEED) begin
        step <= step + 1'b1;
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            a_r[i][j] <= a_in[i][j];
            b_r[i][j] <= b_in[i][j];
            if (sum[i][j][ACC_WIDTH]) begin
              acc[i][j]   <= '1;
              sat[i*N+j]  <= 1'b1;
            end else begin
              acc[i][j]   <= sum[i][j][ACC_WIDTH-1:0];
            end
          end
        end
      end
      if (state == LOAD) begin
        out_sat <= |sat;
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            c_flat[(i*N+j)*ACC_WIDTH +: ACC_WIDTH] <= acc[i][j];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_array_nxn.sv
// tb/tb_systolic_array_nxn.sv - scoreboard bench for systolic_array_nxn (N=2 and N=4 instances)
module tb_systolic_array_nxn;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0, in_accum = 1'b0, out_ready = 1'b1;
  logic [15:0] a_flat = '0, b_flat = '0;
  logic        in_ready, out_valid, out_sat;
  logic [35:0] c_flat;

  logic         in_valid4 = 1'b0, in_ready4, out_valid4, out_sat4;
  logic [63:0]  a4 = '0, b4 = '0;
  logic [159:0] c4;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [36:0] exp_q[$];
  int          lat_q[$];
  int          model_c [2][2];
  bit          model_s [2][2];
  bit          seen = 0, chk_low = 0;

  systolic_array_nxn #(.N(2), .DATA_WIDTH(4), .ACC_WIDTH(9)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_accum(in_accum),
    .a_flat(a_flat), .b_flat(b_flat), .out_valid(out_valid), .out_ready(out_ready),
    .c_flat(c_flat), .out_sat(out_sat)
  );

  systolic_array_nxn #(.N(4), .DATA_WIDTH(4), .ACC_WIDTH(10)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid4), .in_ready(in_ready4), .in_accum(1'b0),
    .a_flat(a4), .b_flat(b4), .out_valid(out_valid4), .out_ready(1'b1),
    .c_flat(c4), .out_sat(out_sat4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Scoreboard: model updated and pushed on acceptance, popped on retirement.
  always @(negedge clk) begin
    if (rstn) begin
      if (chk_low) begin
        check("valid_one_cycle", {31'd0, out_valid}, 32'd0);
        chk_low = 0;
      end
      if (out_valid && !seen) begin
        seen = 1;
        if (lat_q.size() == 0) check("spurious_valid", 32'd1, 32'd0);
        else check("latency", cyc - lat_q.pop_front(), 32'd5);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          for (int k = 0; k < 4; k++)
            check($sformatf("c%0d", k), {23'd0, c_flat[k*9 +: 9]}, {23'd0, e[k*9 +: 9]});
          check("out_sat", {31'd0, out_sat}, {31'd0, e[36]});
        end
        seen = 0;
        chk_low = 1;
      end
      if (in_valid && in_ready) begin
        logic [36:0] w;
        logic        s;
        s = 0;
        for (int i = 0; i < 2; i++) begin
          for (int j = 0; j < 2; j++) begin
            if (!in_accum) begin model_c[i][j] = 0; model_s[i][j] = 0; end
            for (int k = 0; k < 2; k++) begin
              model_c[i][j] += int'(a_flat[(i*2+k)*4 +: 4]) * int'(b_flat[(k*2+j)*4 +: 4]);
              if (model_c[i][j] > 511) begin model_c[i][j] = 511; model_s[i][j] = 1; end
            end
            w[(i*2+j)*9 +: 9] = model_c[i][j][8:0];
            s = s | model_s[i][j];
          end
        end
        w[36] = s;
        exp_q.push_back(w);
        lat_q.push_back(cyc + 1);
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic acc);
    a_flat = a; b_flat = b; in_accum = acc; in_valid = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int t = 0; t < 200; t++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) return;
    end
    check("drain_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int e0;
    bit got;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin model_c[i][j] = 0; model_s[i][j] = 0; end
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_c_flat", {28'd0, |c_flat}, 32'd0);
    check("rst_out_sat", {31'd0, out_sat}, 32'd0);
    rstn = 1'b1;

    send(16'h4321, 16'h8765, 1'b0); wait_drain();
    send(16'h4321, 16'h8765, 1'b1); wait_drain();
    send(16'hFFFF, 16'hFFFF, 1'b0); wait_drain();
    send(16'hFFFF, 16'hFFFF, 1'b1); wait_drain();
    send(16'h0000, 16'h0000, 1'b0); wait_drain();

    send(16'h4321, 16'h8765, 1'b0);
    send(16'h1234, 16'h5678, 1'b0);
    wait_drain();

    // Backpressure with the next operands already waiting.
    out_ready = 1'b0;
    send(16'h4321, 16'h8765, 1'b0);
    a_flat = 16'hFFFF; b_flat = 16'hFFFF; in_accum = 1'b0; in_valid = 1'b1;
    got = 0;
    for (int t = 0; t < 50 && !got; t++) begin
      @(posedge clk); #1;
      got = out_valid;
    end
    check("bp_valid_seen", {31'd0, got}, 32'd1);
    for (int t = 0; t < 10; t++) begin
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_c00", {23'd0, c_flat[0 +: 9]}, 32'd19);
      check("bp_c11", {23'd0, c_flat[27 +: 9]}, 32'd50);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_drain();

    // Asynchronous reset in the middle of FEED.
    send(16'h4321, 16'h8765, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_c_flat", {28'd0, |c_flat}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete(); lat_q.delete(); seen = 0; chk_low = 0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin model_c[i][j] = 0; model_s[i][j] = 0; end
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    send(16'h4321, 16'h8765, 1'b1); wait_drain();

    // N=4: identity times B gives B.
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < 4; k++) begin
        a4[(i*4+k)*4 +: 4] = (i == k) ? 4'd1 : 4'd0;
        b4[(i*4+k)*4 +: 4] = 4'(4*i + k);
      end
    in_valid4 = 1'b1;
    @(negedge clk);
    check("n4_in_ready", {31'd0, in_ready4}, 32'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    e0 = cyc;
    got = 0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      got = out_valid4;
    end
    check("n4_valid_seen", {31'd0, got}, 32'd1);
    check("n4_latency", cyc - e0, 32'd11);
    for (int k = 0; k < 16; k++)
      check($sformatf("n4_c%0d", k), {22'd0, c4[k*10 +: 10]}, k);
    check("n4_out_sat", {31'd0, out_sat4}, 32'd0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_array_nxn.md
# systolic_array_nxn

Parametrised output-stationary systolic matrix multiplier computing C = A×B, or C = C + A×B, for unsigned N×N operand matrices. It is the successor to the fixed 2×2 array: N, operand width and accumulator width are generic. Operands arrive as whole matrices over a valid/ready handshake and are skewed internally. Results are held under valid/ready backpressure, with an accumulate mode for tiled products and saturating accumulators with an overflow flag.

## Interface
- N, 2, matrix dimension (≥2).
- DATA_WIDTH, 4, unsigned operand element width.
- ACC_WIDTH, 9, accumulator/result element width; must be ≥ 2·DATA_WIDTH + clog2(N).
- clk  input  1  single clock; all state updates on rising edge.
- rstn  input  1  reset; asynchronous, active-low.
- in_valid  input  1  operand pair present.
- in_ready  output  1  block can accept operands this cycle.
- in_accum  input  1  sampled with operands: 1 = add onto previous result, 0 = clear first.
- a_flat  input  N·N·DATA_WIDTH  element A[i][k] at bits [(i·N+k)·DATA_WIDTH +: DATA_WIDTH].
- b_flat  input  N·N·DATA_WIDTH  element B[k][j], same packing.
- out_valid  output  1  result held on c_flat.
- out_ready  input  1  consumer takes the result.
- c_flat  output  N·N·ACC_WIDTH  element C[i][j] at bits [(i·N+j)·ACC_WIDTH +: ACC_WIDTH].
- out_sat  output  1  at least one element of this result saturated.

## Operation
- Acceptance: a rising edge with in_valid && in_ready. At that edge, a_flat, b_flat and in_accum are captured into skew registers. If in_accum=0, all N·N accumulators clear.
- FSM states and transitions:
  - IDLE: in_ready=1.
  - FEED: counts 3N−2 compute steps.
  - LOAD: one cycle; copies the accumulators into the c_flat register.
  - HOLD: out_valid=1.
  - Transitions: IDLE→FEED on acceptance. FEED→LOAD after step 3N−3. LOAD→HOLD. HOLD→IDLE on out_ready, or HOLD→FEED if a new acceptance occurs on the same edge.
- in_ready = (state==IDLE) || (state==HOLD && out_ready). It is combinational on out_ready. It is low in FEED and LOAD; in_valid asserted then is ignored, and the source must hold its operands stable.
- Dataflow:
  - Row i of A enters PE(i,0) delayed by i steps and shifts right one PE per step.
  - Column j of B enters PE(0,j) delayed by j steps and shifts down one PE per step.
  - At step s (0…3N−3), PE(i,j) multiplies A[i][s−i−j] by B[s−i−j][j] when 0 ≤ s−i−j < N. Otherwise it sees zero operands and holds its value.
- Arithmetic: all values unsigned. Product width is 2·DATA_WIDTH, zero-extended to ACC_WIDTH.
- Saturation: each PE's sum saturates at 2^ACC_WIDTH−1. A per-PE sticky sat bit sets when saturation occurs. Sat bits clear on acceptance with in_accum=0 and are kept when in_accum=1.
- out_sat is the OR of all sat bits, registered in LOAD.
- With in_accum=1, the accumulators start from the last computed result, including saturated values.
- c_flat and out_sat change only in LOAD. They are stable throughout HOLD and after returning to IDLE, until the next LOAD.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, in_ready=1, out_valid=0, c_flat=0, out_sat=0, all accumulators, sat bits, skew registers and pipelines = 0.
- Latency: if acceptance occurs at edge E0, out_valid rises after edge E(3N−1). That is 5 cycles for N=2 and 11 cycles for N=4.
- Throughput: with out_ready tied high, one result per 3N cycles. A new acceptance occurs on the same edge that retires the previous result.
- out_valid falls after the edge where out_valid && out_ready, unless a new acceptance occurred on that edge. In that case out_valid still falls and the next result follows 3N−1 edges later.
- Reset asserted mid-FEED or mid-HOLD discards the in-flight job with no partial output. The first acceptance after reset treats in_accum as 0 because the accumulators are already 0.
- in_accum is ignored outside the acceptance edge.

## Test plan
- N=2, DW=4, AW=9; A=[[1,2],[3,4]], B=[[5,6],[7,8]], in_accum=0, out_ready=1 -> C=[[19,22],[43,50]], out_sat=0, out_valid high exactly 5 cycles after acceptance, for one cycle.
- Repeat the same operands with in_accum=1 -> C=[[38,44],[86,100]], out_sat=0.
- All elements of A and B = 15, in_accum=0 -> every C element 450. Repeat with in_accum=1 -> every C element 511, out_sat=1. Then A=B=0 with in_accum=0 -> C=0, out_sat=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> c_flat stable and in_ready=0, with in_valid held high throughout. Then raise out_ready -> acceptance on the same edge, and the next result 5 cycles later.
- Deassert rstn mid-FEED -> out_valid=0, c_flat=0 immediately, no result emitted. After release, a fresh job gives the correct C.
- N=4, AW=10; A=identity, B[k][j]=4k+j -> C=B, out_valid 11 cycles after acceptance.
